// File: rtl/video_timing_pkg.sv
// Raster timing constants shared by the video timing slice.
// Default set is 1024x768@60 on a 65 MHz pixel clock.
package video_timing_pkg;

   localparam int unsigned H_ACTIVE = 1024;
   localparam int unsigned H_FP     = 24;
   localparam int unsigned H_SYNC   = 136;
   localparam int unsigned H_BP     = 160;
   localparam int unsigned H_TOTAL  =
      H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int unsigned V_ACTIVE = 768;
   localparam int unsigned V_FP     = 3;
   localparam int unsigned V_SYNC   = 6;
   localparam int unsigned V_BP     = 29;
   localparam int unsigned V_TOTAL  =
      V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int unsigned HCOUNT_W = 11;
   localparam int unsigned VCOUNT_W = 10;

   // True when lo <= x < lo+len, evaluated at full 32-bit width.
   function automatic logic in_window(
      input int unsigned x,
      input int unsigned lo,
      input int unsigned len
   );
      return (x >= lo) && (x < lo + len);
   endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Reset-initialised shift register that delays the sync/blank bundle.
// DEPTH of zero collapses to a straight wire.
module sync_delay_line
   import video_timing_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 3,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_wire
         assign dout = din;
      end else begin : g_sr
         logic [WIDTH-1:0] sr [DEPTH];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) begin
                  sr[i] <= RST_VAL;
               end
            end else begin
               sr[0] <= din;
               for (int i = 1; i < DEPTH; i++) begin
                  sr[i] <= sr[i-1];
               end
            end
         end

         assign dout = sr[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Raster counters, registered sync/blank decode and vblank strobe.
// Sync/blank are also re-emitted through a pipeline-matching delay.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = video_timing_pkg::H_ACTIVE,
   parameter int unsigned H_FP       = video_timing_pkg::H_FP,
   parameter int unsigned H_SYNC     = video_timing_pkg::H_SYNC,
   parameter int unsigned H_BP       = video_timing_pkg::H_BP,
   parameter int unsigned V_ACTIVE   = video_timing_pkg::V_ACTIVE,
   parameter int unsigned V_FP       = video_timing_pkg::V_FP,
   parameter int unsigned V_SYNC     = video_timing_pkg::V_SYNC,
   parameter int unsigned V_BP       = video_timing_pkg::V_BP,
   parameter bit          SYNC_POL   = 1'b0,
   parameter int unsigned PIPE_DELAY = 2
) (
   input  logic                vclock,
   input  logic                reset,
   output logic [HCOUNT_W-1:0] hcount,
   output logic [VCOUNT_W-1:0] vcount,
   output logic                hsync,
   output logic                vsync,
   output logic                blank,
   output logic                hsync_d,
   output logic                vsync_d,
   output logic                blank_d,
   output logic                vblank_start
);

   localparam int unsigned HT =
      H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VT =
      V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_LO = H_ACTIVE + H_FP;
   localparam int unsigned VS_LO = V_ACTIVE + V_FP;

   localparam logic [2:0] DLY_RST =
      {~SYNC_POL, ~SYNC_POL, 1'b1};

   logic [HCOUNT_W-1:0] hnext;
   logic [VCOUNT_W-1:0] vnext;
   logic                hwrap;
   logic                vwrap;
   logic [31:0]         h32;
   logic [31:0]         v32;
   logic                hs_act;
   logic                vs_act;
   logic                bl_n;
   logic                vbs_n;
   logic [2:0]          dly_q;

   always_comb begin
      hwrap = (32'(hcount) == HT - 1);
      vwrap = (32'(vcount) == VT - 1);
      hnext = hcount + HCOUNT_W'(1);
      vnext = vcount;
      if (hwrap) begin
         hnext = '0;
         vnext = vwrap ? '0 : vcount + VCOUNT_W'(1);
      end
   end

   // Decode the upcoming count so registered outputs line up with it.
   always_comb begin
      h32    = 32'(hnext);
      v32    = 32'(vnext);
      hs_act = in_window(h32, HS_LO, H_SYNC);
      vs_act = in_window(v32, VS_LO, V_SYNC);
      bl_n   = (h32 >= H_ACTIVE) || (v32 >= V_ACTIVE);
      vbs_n  = (hnext == '0) && (v32 == V_ACTIVE);
   end

   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         hcount       <= '0;
         vcount       <= '0;
         hsync        <= ~SYNC_POL;
         vsync        <= ~SYNC_POL;
         blank        <= 1'b0;
         vblank_start <= 1'b0;
      end else begin
         hcount       <= hnext;
         vcount       <= vnext;
         hsync        <= hs_act ? SYNC_POL : ~SYNC_POL;
         vsync        <= vs_act ? SYNC_POL : ~SYNC_POL;
         blank        <= bl_n;
         vblank_start <= vbs_n;
      end
   end

   sync_delay_line #(
      .DEPTH   (PIPE_DELAY),
      .WIDTH   (3),
      .RST_VAL (DLY_RST)
   ) u_dly (
      .clk  (vclock),
      .rst  (reset),
      .din  ({hsync, vsync, blank}),
      .dout (dly_q)
   );

   assign hsync_d = dly_q[2];
   assign vsync_d = dly_q[1];
   assign blank_d = dly_q[0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default, zero-delay,
// mid-size and tiny active-high configurations side by side.
module tb_video_timing_gen;

   logic vclock = 1'b0;
   logic reset  = 1'b1;

   always #5 vclock = ~vclock;

   logic [10:0] d_hc, z_hc, m_hc, s_hc;
   logic [9:0]  d_vc, z_vc, m_vc, s_vc;
   logic d_hs, d_vs, d_bl, d_hsd, d_vsd, d_bld, d_vbs;
   logic z_hs, z_vs, z_bl, z_hsd, z_vsd, z_bld, z_vbs;
   logic m_hs, m_vs, m_bl, m_hsd, m_vsd, m_bld, m_vbs;
   logic s_hs, s_vs, s_bl, s_hsd, s_vsd, s_bld, s_vbs;

   video_timing_gen u_def (
      .vclock(vclock), .reset(reset),
      .hcount(d_hc), .vcount(d_vc),
      .hsync(d_hs), .vsync(d_vs), .blank(d_bl),
      .hsync_d(d_hsd), .vsync_d(d_vsd), .blank_d(d_bld),
      .vblank_start(d_vbs)
   );

   video_timing_gen #(.PIPE_DELAY(0)) u_pd0 (
      .vclock(vclock), .reset(reset),
      .hcount(z_hc), .vcount(z_vc),
      .hsync(z_hs), .vsync(z_vs), .blank(z_bl),
      .hsync_d(z_hsd), .vsync_d(z_vsd), .blank_d(z_bld),
      .vblank_start(z_vbs)
   );

   video_timing_gen #(
      .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(8),
      .V_ACTIVE(48), .V_FP(3), .V_SYNC(6), .V_BP(29),
      .SYNC_POL(1'b0), .PIPE_DELAY(2)
   ) u_mid (
      .vclock(vclock), .reset(reset),
      .hcount(m_hc), .vcount(m_vc),
      .hsync(m_hs), .vsync(m_vs), .blank(m_bl),
      .hsync_d(m_hsd), .vsync_d(m_vsd), .blank_d(m_bld),
      .vblank_start(m_vbs)
   );

   video_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1'b1), .PIPE_DELAY(1)
   ) u_sml (
      .vclock(vclock), .reset(reset),
      .hcount(s_hc), .vcount(s_vc),
      .hsync(s_hs), .vsync(s_vs), .blank(s_bl),
      .hsync_d(s_hsd), .vsync_d(s_vsd), .blank_d(s_bld),
      .vblank_start(s_vbs)
   );

   int checks = 0;
   int errors = 0;

   int hfirst, hlast, hcnt, blrise;
   int vfirst, vlast;
   int m_pulses, m_pulse_h, m_pulse_v, m_pulse_n;
   int m_wrap_h, m_wrap_v;
   int s_pulses;

   task automatic check(
      input string tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] dec(
      input int h, input int v,
      input int ha, input int hf, input int hs,
      input int va, input int vf, input int vs,
      input logic pol
   );
      logic ha_on, va_on, bl;
      ha_on = (h >= ha + hf) && (h < ha + hf + hs);
      va_on = (v >= va + vf) && (v < va + vf + vs);
      bl    = (h >= ha) || (v >= va);
      return {ha_on ? pol : ~pol, va_on ? pol : ~pol, bl};
   endfunction

   task automatic chk_dut(
      input string nm, input int n,
      input int ha, input int hf, input int hs, input int hb,
      input int va, input int vf, input int vs, input int vb,
      input logic pol, input int pd,
      input logic [10:0] hc, input logic [9:0] vc,
      input logic hy, input logic vy, input logic bl,
      input logic hyd, input logic vyd, input logic bld,
      input logic vbs
   );
      int ht, vt, h, v;
      logic [2:0] e, ed;
      ht = ha + hf + hs + hb;
      vt = va + vf + vs + vb;
      h  = n % ht;
      v  = (n / ht) % vt;
      e  = dec(h, v, ha, hf, hs, va, vf, vs, pol);
      if (n >= pd)
         ed = dec((n - pd) % ht, ((n - pd) / ht) % vt,
                  ha, hf, hs, va, vf, vs, pol);
      else
         ed = {~pol, ~pol, 1'b1};
      check({nm, ".hc"}, hc, h);
      check({nm, ".vc"}, vc, v);
      check({nm, ".hs"}, hy, e[2]);
      check({nm, ".vs"}, vy, e[1]);
      check({nm, ".bl"}, bl, e[0]);
      check({nm, ".hsd"}, hyd, ed[2]);
      check({nm, ".vsd"}, vyd, ed[1]);
      check({nm, ".bld"}, bld, ed[0]);
      check({nm, ".vbs"}, vbs, (h == 0) && (v == va));
   endtask

   task automatic chk_all(input int n, input bit dflt);
      if (dflt) begin
         chk_dut("def", n, 1024, 24, 136, 160, 768, 3, 6, 29,
                 1'b0, 2, d_hc, d_vc, d_hs, d_vs, d_bl,
                 d_hsd, d_vsd, d_bld, d_vbs);
         chk_dut("pd0", n, 1024, 24, 136, 160, 768, 3, 6, 29,
                 1'b0, 0, z_hc, z_vc, z_hs, z_vs, z_bl,
                 z_hsd, z_vsd, z_bld, z_vbs);
      end
      chk_dut("mid", n, 64, 4, 8, 8, 48, 3, 6, 29,
              1'b0, 2, m_hc, m_vc, m_hs, m_vs, m_bl,
              m_hsd, m_vsd, m_bld, m_vbs);
      chk_dut("sml", n, 8, 2, 2, 2, 4, 1, 1, 1,
              1'b1, 1, s_hc, s_vc, s_hs, s_vs, s_bl,
              s_hsd, s_vsd, s_bld, s_vbs);
   endtask

   task automatic clr_stats();
      hfirst = -1; hlast = -1; hcnt = 0; blrise = -1;
      vfirst = -1; vlast = -1;
      m_pulses = 0; m_pulse_h = -1; m_pulse_v = -1;
      m_pulse_n = -1; m_wrap_h = -1; m_wrap_v = -1;
      s_pulses = 0;
   endtask

   task automatic run(input int ncyc);
      logic pv;
      pv = m_vs;
      for (int n = 1; n <= ncyc; n++) begin
         @(negedge vclock);
         chk_all(n, n <= 2 * 1344);
         if (n == 1) begin
            check("def.hc_edge1", d_hc, 1);
            check("def.bld_edge1", d_bld, 1);
         end
         if (n == 2) check("def.bld_edge2", d_bld, 0);
         if (n == 1343) begin
            check("def.hc_pre_wrap", d_hc, 1343);
            check("def.vc_pre_wrap", d_vc, 0);
         end
         if (n == 1344) begin
            check("def.hc_wrap", d_hc, 0);
            check("def.vc_wrap", d_vc, 1);
         end
         if (n <= 1343) begin
            if (d_hs == 1'b0) begin
               if (hfirst < 0) hfirst = int'(d_hc);
               hlast = int'(d_hc);
               hcnt++;
            end
            if (d_bl && blrise < 0) blrise = int'(d_hc);
         end
         if (m_vs !== pv) check("mid.vs_edge_h0", m_hc, 0);
         pv = m_vs;
         if (m_vs == 1'b0) begin
            if (vfirst < 0) vfirst = int'(m_vc);
            vlast = int'(m_vc);
         end
         if (m_vbs) begin
            m_pulses++;
            m_pulse_h = int'(m_hc);
            m_pulse_v = int'(m_vc);
            m_pulse_n = n;
         end
         if (n == 84 * 86) begin
            m_wrap_h = int'(m_hc);
            m_wrap_v = int'(m_vc);
         end
         if (s_vbs) s_pulses++;
      end
   endtask

   task automatic frame_checks(input int s_exp);
      check("def.hs_first", hfirst, 1048);
      check("def.hs_last", hlast, 1183);
      check("def.hs_len", hcnt, 136);
      check("def.bl_rise", blrise, 1024);
      check("mid.vs_first", vfirst, 51);
      check("mid.vs_last", vlast, 56);
      check("mid.pulses", m_pulses, 1);
      check("mid.pulse_h", m_pulse_h, 0);
      check("mid.pulse_v", m_pulse_v, 48);
      check("mid.pulse_n", m_pulse_n, 4032);
      check("mid.wrap_h", m_wrap_h, 0);
      check("mid.wrap_v", m_wrap_v, 0);
      check("sml.pulses", s_pulses, s_exp);
   endtask

   initial begin
      reset = 1'b1;
      repeat (5) @(negedge vclock);
      check("rst.hc", d_hc, 0);
      check("rst.vc", d_vc, 0);
      check("rst.bl", d_bl, 0);
      check("rst.hs", d_hs, 1);
      check("rst.vs", d_vs, 1);
      check("rst.bld", d_bld, 1);
      check("rst.sml_hs", s_hs, 0);
      chk_all(0, 1'b1);
      reset = 1'b0;
      chk_all(0, 1'b1);

      clr_stats();
      run(9794);
      frame_checks(100);
      check("mid.pre_rst_hc", m_hc, 50);
      check("mid.pre_rst_vc", m_vc, 30);

      reset = 1'b1;
      #1;
      check("arst.mid_hc", m_hc, 0);
      check("arst.def_bld", d_bld, 1);
      chk_all(0, 1'b1);
      @(negedge vclock);
      reset = 1'b0;
      chk_all(0, 1'b1);

      clr_stats();
      run(84 * 86 + 10);
      frame_checks(74);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
